alu_share_arbiter: RTL and testbench

Shares one ALU datapath between two issue slots (slot 0, slot 1) of the superscalar core. Each slot uses a valid/ready handshake. A round-robin arbiter grants one request per cycle. The granted operation executes on the shared ALU and the result is registered into a one-entry output stage, which drains to writeback through a valid/ready handshake.

---
 rtl/alu_share_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two issue slots share one ALU datapath.
//
// A round-robin arbiter picks at most one request per cycle. The chosen operation runs through
// the ALU and its result is captured in a one-entry output stage that drains to writeback over
// a valid/ready handshake. The stage can drain and refill in the same cycle.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   req{0,1}_valid / _ready     per-slot request handshake
//   req{0,1}_alucontrol         3-bit ALU op code
//   req{0,1}_a, _b, _shamt      operands and shift amount
//   req{0,1}_tag                tag returned alongside the result
//   res_valid / res_ready       output stage handshake
//   res_src, res_tag            issuing slot and its tag
//   res_data, res_zero          ALU result and (res_data == 0)
//
// Optional build macro ALU_ARB_PERF_EN adds perf_conflict_cnt (cycles with both slots valid)
// and perf_stall_cnt (cycles with the output stage stalled). Both are 32-bit and wrap.

module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_alucontrol,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [4:0]       req0_shamt,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_alucontrol,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [4:0]       req1_shamt,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_src,
  output logic [TAG_W-1:0] res_tag,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]      perf_conflict_cnt,
  output logic [31:0]      perf_stall_cnt
`endif
);

  logic             res_valid_q, res_valid_d;
  logic             res_src_q, res_src_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d;
  logic             last_grant_q, last_grant_d;

  logic             can_accept;
  logic             gnt_sel;
  logic             accept;

  logic [2:0]              sel_op;
  logic [WIDTH-1:0]        sel_a;
  logic [WIDTH-1:0]        sel_b;
  logic [4:0]              sel_shamt;
  logic [TAG_W-1:0]        sel_tag;
  logic signed [WIDTH-1:0] sel_b_s;
  logic [WIDTH-1:0]        alu_y;

  // Arbitration. gnt_sel is only meaningful when accept is high.
  always_comb begin
    can_accept = !res_valid_q || res_ready;
    gnt_sel    = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_sel = ~last_grant_q;
    end else if (req1_valid) begin
      gnt_sel = 1'b1;
    end
    // Reset drops any same-cycle accept, so ready is forced low while reset is high.
    accept = (req0_valid || req1_valid) && can_accept && !reset;
  end

  assign req0_ready = accept && !gnt_sel;
  assign req1_ready = accept && gnt_sel;

  // Operand mux feeding the shared ALU.
  always_comb begin
    if (gnt_sel) begin
      sel_op    = req1_alucontrol;
      sel_a     = req1_a;
      sel_b     = req1_b;
      sel_shamt = req1_shamt;
      sel_tag   = req1_tag;
    end else begin
      sel_op    = req0_alucontrol;
      sel_a     = req0_a;
      sel_b     = req0_b;
      sel_shamt = req0_shamt;
      sel_tag   = req0_tag;
    end
  end

  assign sel_b_s = sel_b;

  // Shared ALU. Shifts take their data from operand B; operand A is unused for them.
  always_comb begin
    alu_y = '0;
    case (sel_op)
      3'b000: alu_y = sel_a & sel_b;
      3'b001: alu_y = sel_a | sel_b;
      3'b010: alu_y = sel_a + sel_b;
      3'b011: alu_y = sel_a - sel_b;
      3'b100: alu_y = sel_b << sel_shamt;
      3'b101: alu_y = sel_b >> sel_shamt;
      3'b110: alu_y = sel_b_s >>> sel_shamt;
      3'b111: alu_y[0] = $signed(sel_a) < $signed(sel_b);
      default: alu_y = '0;
    endcase
  end

  // Output stage next state.
  always_comb begin
    res_valid_d  = res_valid_q;
    res_src_d    = res_src_q;
    res_tag_d    = res_tag_q;
    res_data_d   = res_data_q;
    res_zero_d   = res_zero_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      res_valid_d  = 1'b1;
      res_src_d    = gnt_sel;
      res_tag_d    = sel_tag;
      res_data_d   = alu_y;
      res_zero_d   = (alu_y == '0);
      last_grant_d = gnt_sel;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q  <= 1'b0;
      res_src_q    <= 1'b0;
      res_tag_q    <= '0;
      res_data_q   <= '0;
      res_zero_q   <= 1'b1;
      // Pointing at slot 1 lets slot 0 win the first conflict.
      last_grant_q <= 1'b1;
    end else begin
      res_valid_q  <= res_valid_d;
      res_src_q    <= res_src_d;
      res_tag_q    <= res_tag_d;
      res_data_q   <= res_data_d;
      res_zero_q   <= res_zero_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_src   = res_src_q;
  assign res_tag   = res_tag_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_conflict_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_conflict_q <= '0;
      perf_stall_q    <= '0;
    end else begin
      if (req0_valid && req1_valid) begin
        perf_conflict_q <= perf_conflict_q + 32'd1;
      end
      if (res_valid_q && !res_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_conflict_cnt = perf_conflict_q;
  assign perf_stall_cnt    = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the arbiter and output stage.

module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_alucontrol, req1_alucontrol;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_shamt, req1_shamt;
  logic [3:0]  req0_tag, req1_tag;
  logic        res_valid, res_ready, res_src, res_zero;
  logic [3:0]  res_tag;
  logic [31:0] res_data;
`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_conflict_cnt, perf_stall_cnt;
`endif

  alu_share_arbiter #(
    .WIDTH(32),
    .TAG_W(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req0_valid     (req0_valid),
    .req0_ready     (req0_ready),
    .req0_alucontrol(req0_alucontrol),
    .req0_a         (req0_a),
    .req0_b         (req0_b),
    .req0_shamt     (req0_shamt),
    .req0_tag       (req0_tag),
    .req1_valid     (req1_valid),
    .req1_ready     (req1_ready),
    .req1_alucontrol(req1_alucontrol),
    .req1_a         (req1_a),
    .req1_b         (req1_b),
    .req1_shamt     (req1_shamt),
    .req1_tag       (req1_tag),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_src        (res_src),
    .res_tag        (res_tag),
    .res_data       (res_data),
    .res_zero       (res_zero)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_conflict_cnt(perf_conflict_cnt),
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: contents of the output stage and who won the last transfer.
  logic        m_valid = 1'b0;
  logic        m_src, m_zero, m_last;
  logic [3:0]  m_tag;
  logic [31:0] m_data;
  logic        m_known = 1'b0;
  logic        m_fresh = 1'b0;
  logic [31:0] m_conf, m_stall;
  logic        s_r0, s_r1;
  logic        acc0 = 1'b0, acc1 = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] ones;
    int signed   sa, sb;
    ones = 32'hFFFF_FFFF;
    sa   = a;
    sb   = b;
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return a + ~b + 32'd1;
      3'd4: return b << sh;
      3'd5: return b >> sh;
      3'd6: return (b >> sh) | (b[31] ? ~(ones >> sh) : 32'd0);
      default: return (sa < sb) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Called just after a falling edge with inputs driven; checks this cycle, advances the model,
  // and returns at the next falling edge.
  task automatic step();
    logic e0, e1, can;
    #1;
    can = !m_valid || res_ready;
    e0  = 1'b0;
    e1  = 1'b0;
    if (!reset && can) begin
      if (req0_valid && req1_valid) begin
        if (m_last) e0 = 1'b1;
        else        e1 = 1'b1;
      end else if (req0_valid) begin
        e0 = 1'b1;
      end else if (req1_valid) begin
        e1 = 1'b1;
      end
    end
    s_r0 = req0_ready;
    s_r1 = req1_ready;
    check_eq("req0_ready", req0_ready, e0);
    check_eq("req1_ready", req1_ready, e1);
    if (m_known) begin
      check_eq("res_valid", res_valid, m_valid);
      if (m_valid || m_fresh) begin
        check_eq("res_src", res_src, m_src);
        check_eq("res_tag", res_tag, m_tag);
        check_eq("res_data", res_data, m_data);
        check_eq("res_zero", res_zero, m_zero);
      end
`ifdef ALU_ARB_PERF_EN
      check_eq("perf_conflict", perf_conflict_cnt, m_conf);
      check_eq("perf_stall", perf_stall_cnt, m_stall);
`endif
    end
    if (reset) begin
      m_known = 1'b1;
      m_fresh = 1'b1;
      m_valid = 1'b0;
      m_src   = 1'b0;
      m_tag   = '0;
      m_data  = '0;
      m_zero  = 1'b1;
      m_last  = 1'b1;
      m_conf  = '0;
      m_stall = '0;
    end else begin
      if (req0_valid && req1_valid) m_conf = m_conf + 32'd1;
      if (m_valid && !res_ready)    m_stall = m_stall + 32'd1;
      if (e0 || e1) begin
        m_fresh = 1'b0;
        m_valid = 1'b1;
        m_src   = e1;
        m_last  = e1;
        m_tag   = e1 ? req1_tag : req0_tag;
        m_data  = e1 ? ref_alu(req1_alucontrol, req1_a, req1_b, req1_shamt)
                     : ref_alu(req0_alucontrol, req0_a, req0_b, req0_shamt);
        m_zero  = (m_data == 32'd0);
      end else if (res_ready) begin
        m_valid = 1'b0;
      end
    end
    acc0 = e0;
    acc1 = e1;
    @(negedge clk);
  endtask

  task automatic set_req(input int slot, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [3:0] tag);
    if (slot == 0) begin
      req0_valid = 1'b1; req0_alucontrol = op; req0_a = a; req0_b = b;
      req0_shamt = sh;   req0_tag = tag;
    end else begin
      req1_valid = 1'b1; req1_alucontrol = op; req1_a = a; req1_b = b;
      req1_shamt = sh;   req1_tag = tag;
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // One slot-0 op with an always-ready consumer; the result is checked against a constant.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] expv);
    set_req(0, op, a, b, sh, 4'd7);
    res_ready = 1'b1;
    step();
    req0_valid = 1'b0;
    check_eq(tag, res_data, expv);
  endtask

  initial begin
    reset = 1'b1;
    res_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_alucontrol = '0; req0_a = '0; req0_b = '0; req0_shamt = '0; req0_tag = '0;
    req1_alucontrol = '0; req1_a = '0; req1_b = '0; req1_shamt = '0; req1_tag = '0;
    @(negedge clk);
    do_reset();

    // Reset state.
    check_eq("rst_valid", res_valid, 1'b0);
    check_eq("rst_data", res_data, 32'd0);
    check_eq("rst_zero", res_zero, 1'b1);
    check_eq("rst_tag", res_tag, 4'd0);

    // 1: single add.
    set_req(0, 3'b010, 32'd5, 32'd7, 5'd0, 4'd3);
    res_ready = 1'b1;
    step();
    check_eq("t1_ready", s_r0, 1'b1);
    req0_valid = 1'b0;
    check_eq("t1_valid", res_valid, 1'b1);
    check_eq("t1_src", res_src, 1'b0);
    check_eq("t1_tag", res_tag, 4'd3);
    check_eq("t1_data", res_data, 32'd12);
    check_eq("t1_zero", res_zero, 1'b0);
    step();

    // 2: sustained conflict alternates starting with slot 0.
    do_reset();
    set_req(0, 3'b010, 32'd100, 32'd1, 5'd0, 4'd1);
    set_req(1, 3'b010, 32'd200, 32'd2, 5'd0, 4'd2);
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t2_grant", {s_r1, s_r0}, (i % 2) ? 2'b10 : 2'b01);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq("t2_last_src", res_src, 1'b1);
    check_eq("t2_last_data", res_data, 32'd202);
    step();

    // 3: shifts, signed compare, wrapping subtract.
    run_op("t3_sra", 3'b110, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000);
    run_op("t3_srl", 3'b101, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000);
    run_op("t3_slt", 3'b111, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
    run_op("t3_sub", 3'b011, 32'd0, 32'd1, 5'd0, 32'hFFFF_FFFF);

    // 4: backpressure for three cycles, then drain and refill with no bubble.
    do_reset();
    run_op("t4_fill", 3'b001, 32'h0F, 32'hF0, 5'd0, 32'hFF);
    res_ready = 1'b0;
    set_req(1, 3'b000, 32'hFF00, 32'h0FF0, 5'd0, 4'd5);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t4_hold_rdy", s_r1, 1'b0);
      check_eq("t4_hold_data", res_data, 32'hFF);
    end
    res_ready = 1'b1;
    step();
    check_eq("t4_drain_rdy", s_r1, 1'b1);
    req1_valid = 1'b0;
    check_eq("t4_src", res_src, 1'b1);
    check_eq("t4_tag", res_tag, 4'd5);
    check_eq("t4_data", res_data, 32'h0F00);
`ifdef ALU_ARB_PERF_EN
    check_eq("t4_perf_stall", perf_stall_cnt, 32'd3);
`endif
    step();

    // 5: zero flag.
    run_op("t5_data", 3'b011, 32'd9, 32'd9, 5'd0, 32'd0);
    check_eq("t5_zero", res_zero, 1'b1);

    // 6: reset while a result is held; a same-cycle request is dropped.
    run_op("t6_fill", 3'b010, 32'd1, 32'd2, 5'd0, 32'd3);
    res_ready = 1'b0;
    step();
    reset = 1'b1;
    set_req(1, 3'b010, 32'd4, 32'd4, 5'd0, 4'd9);
    step();
    reset = 1'b0;
    req1_valid = 1'b0;
    check_eq("t6_valid", res_valid, 1'b0);
    check_eq("t6_data", res_data, 32'd0);
    check_eq("t6_zero", res_zero, 1'b1);
    check_eq("t6_src", res_src, 1'b0);
`ifdef ALU_ARB_PERF_EN
    check_eq("t6_perf_conf", perf_conflict_cnt, 32'd0);
    check_eq("t6_perf_stall", perf_stall_cnt, 32'd0);
`endif
    res_ready = 1'b1;
    set_req(0, 3'b000, 32'd1, 32'd1, 5'd0, 4'd1);
    set_req(1, 3'b000, 32'd1, 32'd1, 5'd0, 4'd2);
    step();
    check_eq("t6_first_conflict", s_r0, 1'b1);

    // Randomized traffic; requesters hold their payload until accepted.
    for (int c = 0; c < 4000; c++) begin
      if (!(req0_valid && !acc0)) begin
        req0_valid      = ($urandom_range(0, 99) < 60);
        req0_alucontrol = 3'($urandom_range(0, 7));
        req0_a          = $urandom();
        req0_b          = ($urandom_range(0, 3) == 0) ? req0_a : $urandom();
        req0_shamt      = 5'($urandom_range(0, 31));
        req0_tag        = 4'($urandom_range(0, 15));
      end
      if (!(req1_valid && !acc1)) begin
        req1_valid      = ($urandom_range(0, 99) < 60);
        req1_alucontrol = 3'($urandom_range(0, 7));
        req1_a          = $urandom();
        req1_b          = ($urandom_range(0, 3) == 0) ? req1_a : $urandom();
        req1_shamt      = 5'($urandom_range(0, 31));
        req1_tag        = 4'($urandom_range(0, 15));
      end
      res_ready = ($urandom_range(0, 99) < 70);
      reset     = ($urandom_range(0, 255) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
